// File: rtl/sm83_pkg.sv
// Shared SM83 core types: flag register layout and the wide sequential ALU's
// operation and flag-policy encodings.
package sm83_pkg;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    // Half-carry is the carry out of this bit within a slice
    localparam int unsigned HC_BIT = 3;

    typedef enum logic [3:0] {
        WALU_ADD,
        WALU_ADC,
        WALU_SUB,
        WALU_SBC,
        WALU_CP,
        WALU_AND,
        WALU_OR,
        WALU_XOR,
        WALU_INC,
        WALU_DEC,
        WALU_ADDS
    } walu_op_t;

    typedef enum logic [1:0] {
        FM_FULL,
        FM_ADDHL,
        FM_LOW,
        FM_NONE
    } walu_fmode_t;

    function automatic logic walu_is_sub(input walu_op_t op);
        return (op == WALU_SUB) || (op == WALU_SBC) || (op == WALU_CP);
    endfunction

    function automatic logic walu_is_logic(input walu_op_t op);
        return (op == WALU_AND) || (op == WALU_OR) || (op == WALU_XOR);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE_W-bit slice of the wide ALU: adder (a + b + cin) or bitwise op,
// with carry out of the top bit and out of the half-carry bit.
module alu_slice
    import sm83_pkg::*;
#(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  walu_op_t           op,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               hcout
);

    localparam int unsigned SUM_W = SLICE_W + 1;

    logic [SUM_W-1:0] add_w;

    always_comb begin
        add_w = {1'b0, a} + {1'b0, b} + SUM_W'(cin);
        sum   = add_w[SLICE_W-1:0];
        cout  = add_w[SLICE_W];
        // Carry into bit HC_BIT+1 recovered from the sum bit and both addend bits
        hcout = a[HC_BIT+1] ^ b[HC_BIT+1] ^ add_w[HC_BIT+1];
        case (op)
            WALU_AND: begin
                sum   = a & b;
                cout  = 1'b0;
                hcout = 1'b0;
            end
            WALU_OR: begin
                sum   = a | b;
                cout  = 1'b0;
                hcout = 1'b0;
            end
            WALU_XOR: begin
                sum   = a ^ b;
                cout  = 1'b0;
                hcout = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wide_alu_seq.sv
// Multi-cycle wide ALU: walks WIDTH bits through one SLICE_W-bit slice per
// cycle, chaining carry, then holds the result until the consumer takes it.
module wide_alu_seq
    import sm83_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  walu_op_t         op,
    input  walu_fmode_t      flag_mode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  flags_t           in_flags,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output flags_t           out_flags
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic               accept, step, last;

    walu_op_t           op_q;
    walu_fmode_t        fmode_q;
    logic [WIDTH-1:0]   op1_q, op2_q;
    flags_t             flags_q;
    logic [IDX_W-1:0]   idx;
    logic               carry_q, zacc_q, h0_q, c0_q;

    logic               cin0;
    logic [WIDTH-1:0]   b_full;
    logic [SLICE_W-1:0] a_s, b_s, sum_s, res_s;
    logic               cout_s, hcout_s;
    logic               sub_q, h_live, c_live, h_lo, c_lo, z_all;
    flags_t             flags_nxt;

    assign last = (idx == LAST_IDX);

    // Control: state transitions and datapath enables
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
        end
    end

    // Initial carry from the op and the live flags at accept time
    always_comb begin
        cin0 = 1'b0;
        case (op)
            WALU_ADC: cin0 = in_flags.c;
            WALU_SUB,
            WALU_CP:  cin0 = 1'b1;
            WALU_SBC: cin0 = ~in_flags.c;
            default:  cin0 = 1'b0;
        endcase
    end

    // Full-width second addend; the slice picks its window from it
    always_comb begin
        b_full = op2_q;
        case (op_q)
            WALU_SUB,
            WALU_SBC,
            WALU_CP:   b_full = ~op2_q;
            WALU_INC:  b_full = WIDTH'(1);
            WALU_DEC:  b_full = '1;
            WALU_ADDS: b_full = WIDTH'($signed(op2_q[SLICE_W-1:0]));
            default:   b_full = op2_q;
        endcase
    end

    assign a_s = op1_q[idx*SLICE_W +: SLICE_W];
    assign b_s = b_full[idx*SLICE_W +: SLICE_W];

    alu_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a     (a_s),
        .b     (b_s),
        .cin   (carry_q),
        .op    (op_q),
        .sum   (sum_s),
        .cout  (cout_s),
        .hcout (hcout_s)
    );

    // Flag values for the slice in flight; subtracts report borrow
    always_comb begin
        sub_q  = walu_is_sub(op_q);
        res_s  = (op_q == WALU_CP) ? a_s : sum_s;
        h_live = sub_q ? ~hcout_s : hcout_s;
        c_live = sub_q ? ~cout_s : cout_s;
        h_lo   = (idx == '0) ? h_live : h0_q;
        c_lo   = (idx == '0) ? c_live : c0_q;
        z_all  = ((idx == '0) ? 1'b1 : zacc_q) & (sum_s == '0);
    end

    // Final flags, only meaningful on the last EXEC cycle
    always_comb begin
        flags_nxt = flags_q;
        case (fmode_q)
            FM_FULL: begin
                flags_nxt.z = z_all;
                flags_nxt.n = sub_q;
                flags_nxt.h = h_live;
                flags_nxt.c = c_live;
                if (walu_is_logic(op_q)) begin
                    flags_nxt.h = (op_q == WALU_AND);
                    flags_nxt.c = 1'b0;
                end
            end
            FM_ADDHL: begin
                flags_nxt.z = flags_q.z;
                flags_nxt.n = 1'b0;
                flags_nxt.h = h_live;
                flags_nxt.c = c_live;
            end
            FM_LOW: begin
                flags_nxt.z = 1'b0;
                flags_nxt.n = 1'b0;
                flags_nxt.h = h_lo;
                flags_nxt.c = c_lo;
            end
            default: flags_nxt = flags_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= WALU_ADD;
            fmode_q   <= FM_FULL;
            op1_q     <= '0;
            op2_q     <= '0;
            flags_q   <= '0;
            idx       <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            h0_q      <= 1'b0;
            c0_q      <= 1'b0;
            result    <= '0;
            out_flags <= '0;
        end else if (accept) begin
            op_q    <= op;
            fmode_q <= flag_mode;
            op1_q   <= op1;
            op2_q   <= op2;
            flags_q <= in_flags;
            idx     <= '0;
            carry_q <= cin0;
        end else if (step) begin
            result[idx*SLICE_W +: SLICE_W] <= res_s;
            carry_q <= cout_s;
            zacc_q  <= z_all;
            if (idx == '0) begin
                h0_q <= h_live;
                c0_q <= c_live;
            end
            if (last) begin
                out_flags <= flags_nxt;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: doc/wide_alu_seq.md
Name: wide_alu_seq

Overview:
- Parametrised multi-cycle ALU for wide (16-bit and larger) arithmetic/logic: ADD HL,rr, ADD SP,e8, 16-bit INC/DEC, and wider ops for future extensions.
- Processes WIDTH bits through one SLICE_W-bit adder slice per cycle, chaining carry between slices, so area stays small.
- Sits beside the 8-bit combinational ALU in the core. Operands in and results out use valid/ready handshakes; a flag-policy input selects SM83-style flag semantics.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 8, bits processed per cycle; power of two, ≥8.
- NSLICE, WIDTH/SLICE_W, derived; number of EXEC cycles.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  walu_op_t  operation
- flag_mode  in  walu_fmode_t  flag policy
- op1  in  WIDTH  first operand
- op2  in  WIDTH  second operand; low SLICE_W bits are the signed offset for WALU_ADDS
- in_flags  in  flags_t  current Z/N/H/C
- abort  in  1  synchronous cancel of the operation in flight
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result
- out_flags  out  flags_t  resulting flags

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, out_flags=0. Reset applies asynchronously, including mid-operation.
- FSM states are IDLE, EXEC and DONE.
- IDLE: in_ready=1. When in_valid is high, latch op, flag_mode, op1, op2 and in_flags; set slice index idx=0 and carry_in per op; go to EXEC.
- EXEC: in_ready=0. Each cycle computes slice idx and registers it into result[idx*SLICE_W +: SLICE_W]. The slice's carry-out is the next carry_in.
  - At idx==NSLICE-1, go to DONE and set out_valid=1.
  - Latency: out_valid rises exactly NSLICE cycles after the accept edge.
- DONE: out_valid=1, and result/out_flags stay stable until out_ready is high. On the handshake edge go to IDLE; out_valid falls the same edge. No accept occurs in DONE; the next accept is earliest the following cycle.
- abort: if high in EXEC or DONE, go to IDLE next edge with out_valid=0 and no result delivered. abort in IDLE is ignored. abort takes priority over the out_ready handshake.
- Arithmetic (slice adder is a + b + cin, SLICE_W+1 bits):
  - ADD: b=op2, cin0=0. ADC: cin0=in_flags.c.
  - SUB/CP: b=~op2, cin0=1. SBC: b=~op2, cin0=~in_flags.c. For subtract ops, C and H report borrow (inverted carry).
  - INC/DEC: b=1 and b=-1 respectively (all-ones), cin0=0.
  - ADDS: b=sign-extended op2[SLICE_W-1:0].
  - AND/OR/XOR: bitwise per slice; carry chain forced to 0.
  - CP: flags as SUB; result returns op1 unchanged.
- H: carry/borrow out of bit 3 of the selected slice, i.e. out of bit (s*SLICE_W+3).
- flag_mode:
  - FM_FULL: Z=(result==0), N=subtract op, H from the top slice, C from the final carry.
  - FM_ADDHL: Z=in_flags.z, N=0, H from the top slice, C from the final carry.
  - FM_LOW: Z=0, N=0, H and C from slice 0 (ADD SP,e8 semantics).
  - FM_NONE: out_flags=in_flags (16-bit INC/DEC).
- Logic ops under FM_FULL: AND gives H=1, C=0; OR/XOR give H=0, C=0.
- Carries and H are captured in registers during the relevant EXEC cycle. out_flags updates only on entry to DONE.

Decomposition:
- sm83_pkg gains walu_op_t (WALU_ADD, ADC, SUB, SBC, CP, AND, OR, XOR, INC, DEC, ADDS) and walu_fmode_t (FM_FULL, FM_ADDHL, FM_LOW, FM_NONE).
- It reuses the existing flags_t and gains a localparam for the half-carry bit index (3).
- One sub-module: alu_slice. It is combinational, takes (a, b, cin, op) and returns sum, cout and hcout at SLICE_W width. The FSM, index counter and flag capture stay in wide_alu_seq.

Test Plan:
- WIDTH=16, ADD, FM_ADDHL, op1=0x0FFF, op2=0x0001, in_flags.z=1 -> result 0x1000, Z=1, N=0, H=1, C=0, out_valid exactly 2 cycles after the accept edge.
- SUB, FM_FULL: 0x1000-0x0001 -> 0x0FFF, Z=0, N=1, H=1, C=0. Then 0x0000-0x0001 -> 0xFFFF, C=1.
- ADDS, FM_LOW:
  - op1=0xFFF8, op2=0x0008 -> 0x0000, Z=0, N=0, H=1, C=1.
  - op1=0x0000, op2=0x00FF -> 0xFFFF, H=0, C=0.
- INC, FM_NONE, op1=0xFFFF, in_flags={z=1,n=0,h=1,c=0} -> result 0x0000, out_flags identical to in_flags.
- Handshake and abort:
  - Hold out_ready=0 for 5 cycles -> result/out_flags stable, in_ready=0.
  - abort on the first EXEC cycle -> IDLE next edge, out_valid never rises.
  - rst_n low mid-EXEC -> all outputs at reset values immediately.
- WIDTH=32, ADC, FM_FULL, op1=0xFFFFFFFF, op2=0, in_flags.c=1 -> 0x00000000, Z=1, H=1, C=1, latency 4 cycles.
